// File: rtl/vram_dma_if.sv
// Shared-bus signal bundle between the VRAM DMA engine and the CPU/decode side.
// dma_irq_B exists only when VRAM_DMA_IRQ_EN is defined.
interface vram_dma_if;
  logic        SELECT_dma;
  logic [2:0]  reg_addr;
  logic        write_enable_B;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        in_vblank;
  logic        bus_grant;
  logic        cpu_rdy;
  logic        dma_drive;
  logic [15:0] dma_address;
  logic [7:0]  dma_data_out;
  logic        dma_write_enable_B;
  logic        busy;
`ifdef VRAM_DMA_IRQ_EN
  logic        dma_irq_B;
`endif

  modport master (
    input  SELECT_dma, reg_addr, write_enable_B, data_in, in_vblank, bus_grant,
    output
`ifdef VRAM_DMA_IRQ_EN
           dma_irq_B,
`endif
           data_out, cpu_rdy, dma_drive, dma_address, dma_data_out,
           dma_write_enable_B, busy
  );

  modport slave (
    output SELECT_dma, reg_addr, write_enable_B, data_in, in_vblank, bus_grant,
    input
`ifdef VRAM_DMA_IRQ_EN
           dma_irq_B,
`endif
           data_out, cpu_rdy, dma_drive, dma_address, dma_data_out,
           dma_write_enable_B, busy
  );
endinterface

// File: rtl/vram_dma.sv
// Vblank-gated RAM->VRAM block copier; halts the 6502 via RDY and drives the shared bus.
// Optional completion interrupt (dma_irq_B) enabled by defining VRAM_DMA_IRQ_EN.
module vram_dma #(
  parameter logic [15:0] VRAM_BASE     = 16'h3000,
  parameter int          MAX_LEN_WIDTH = 8
) (
  input  logic      clk_12_5875,
  input  logic      rst_B,
  vram_dma_if.master bus
);
  typedef enum logic [2:0] {IDLE, ARMED, REQ, READ, WRITE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [15:0]              src_q, src_d, wsrc_q, wsrc_d;
  logic [11:0]              dst_q, dst_d, wdst_q, wdst_d;
  logic [MAX_LEN_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [7:0]               buf_q, buf_d;
  logic                     done_q, done_d;
  logic                     busy, reg_wr, reg_rd, cfg_wr, arm;

  assign busy   = (state_q == ARMED) || (state_q == REQ) ||
                  (state_q == READ)  || (state_q == WRITE);
  assign reg_wr = bus.SELECT_dma & ~bus.write_enable_B;
  assign reg_rd = bus.SELECT_dma &  bus.write_enable_B;
  assign cfg_wr = reg_wr & ~busy;
  assign arm    = cfg_wr && (bus.reg_addr == 3'd5);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    wsrc_d  = wsrc_q;
    wdst_d  = wdst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    done_d  = done_q;
    if (cfg_wr) begin
      case (bus.reg_addr)
        3'd0:    src_d[7:0]  = bus.data_in;
        3'd1:    src_d[15:8] = bus.data_in;
        3'd2:    dst_d[7:0]  = bus.data_in;
        3'd3:    dst_d[11:8] = bus.data_in[3:0];
        3'd4:    len_d       = MAX_LEN_WIDTH'(bus.data_in);
        default: ;
      endcase
    end
    case (state_q)
      IDLE, DONE: begin
        // An arm landing in the DONE cycle is honoured rather than dropped.
        if (arm) begin
          state_d = ARMED;
          wsrc_d  = src_q;
          wdst_d  = dst_q;
          cnt_d   = len_q;
          done_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: if (bus.in_vblank) state_d = REQ;
      REQ: begin
        if (!bus.in_vblank)     state_d = ARMED;
        else if (bus.bus_grant) state_d = READ;
      end
      READ: begin
        buf_d   = bus.data_in;
        state_d = WRITE;
      end
      WRITE: begin
        wsrc_d = wsrc_q + 16'd1;
        wdst_d = wdst_q + 12'd1;
        cnt_d  = cnt_q - MAX_LEN_WIDTH'(1);
        // A loaded count of 0 wraps through all 2**MAX_LEN_WIDTH values before hitting 1.
        if (cnt_q == MAX_LEN_WIDTH'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (!bus.in_vblank) begin
          state_d = ARMED;
        end else begin
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_12_5875 or negedge rst_B) begin
    if (!rst_B) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      wsrc_q  <= '0;
      wdst_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      wsrc_q  <= wsrc_d;
      wdst_q  <= wdst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

`ifdef VRAM_DMA_IRQ_EN
  logic irq_b_q, irq_b_d;
  always_comb begin
    irq_b_d = irq_b_q;
    if (state_d == DONE && state_q != DONE)          irq_b_d = 1'b0;
    else if (arm || (reg_rd && bus.reg_addr == 3'd5)) irq_b_d = 1'b1;
  end
  always_ff @(posedge clk_12_5875 or negedge rst_B) begin
    if (!rst_B) irq_b_q <= 1'b1;
    else        irq_b_q <= irq_b_d;
  end
  assign bus.dma_irq_B = irq_b_q;
`endif

  // Bus outputs decode straight from state so an async reset releases the bus at once.
  assign bus.busy               = busy;
  assign bus.cpu_rdy            = !((state_q == REQ) || (state_q == READ) || (state_q == WRITE));
  assign bus.dma_drive          = (state_q == READ) || (state_q == WRITE);
  assign bus.dma_write_enable_B = (state_q != WRITE);
  assign bus.dma_data_out       = (state_q == WRITE) ? buf_q : 8'h00;
  assign bus.dma_address        = (state_q == READ)  ? wsrc_q :
                                  (state_q == WRITE) ? VRAM_BASE + {4'h0, wdst_q} : 16'h0000;

  always_comb begin
    bus.data_out = 8'h00;
    if (reg_rd) begin
      case (bus.reg_addr)
        3'd0:    bus.data_out = src_q[7:0];
        3'd1:    bus.data_out = src_q[15:8];
        3'd2:    bus.data_out = dst_q[7:0];
        3'd3:    bus.data_out = {4'h0, dst_q[11:8]};
        3'd4:    bus.data_out = 8'(len_q);
        3'd5:    bus.data_out = {6'b0, done_q, busy};
        default: bus.data_out = 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_dma.sv
// Directed bench for vram_dma: memory model on the shared bus, write/read monitors,
// immediate-assertion checks with hand-computed expectations.
module tb_vram_dma;
  logic clk = 1'b0;
  logic rst_B;
  always #5 clk = ~clk;

  vram_dma_if ifc();
  vram_dma dut (.clk_12_5875(clk), .rst_B(rst_B), .bus(ifc));

  logic [7:0]  mem [0:65535];
  logic [7:0]  cpu_wdata;
  logic [15:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [15:0] rd_addr[$];
  int passes = 0;
  int total  = 0;
  logic [7:0] rv;

  assign ifc.data_in = ifc.dma_drive ? mem[ifc.dma_address] : cpu_wdata;

  always @(negedge clk) begin
    if (rst_B && ifc.dma_drive) begin
      if (!ifc.dma_write_enable_B) begin
        wr_addr.push_back(ifc.dma_address);
        wr_data.push_back(ifc.dma_data_out);
      end else begin
        rd_addr.push_back(ifc.dma_address);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ifc.SELECT_dma = 1'b1; ifc.write_enable_B = 1'b0; ifc.reg_addr = a; cpu_wdata = d;
    @(negedge clk);
    ifc.SELECT_dma = 1'b0; ifc.write_enable_B = 1'b1;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
    ifc.SELECT_dma = 1'b1; ifc.write_enable_B = 1'b1; ifc.reg_addr = a;
    #1 d = ifc.data_out;
    ifc.SELECT_dma = 1'b0;
  endtask

  task automatic program_xfer(input logic [15:0] s, input logic [11:0] d, input logic [7:0] l);
    cpu_wr(3'd0, s[7:0]);
    cpu_wr(3'd1, s[15:8]);
    cpu_wr(3'd2, d[7:0]);
    cpu_wr(3'd3, {4'h0, d[11:8]});
    cpu_wr(3'd4, l);
    cpu_wr(3'd5, 8'h00);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (ifc.busy !== 1'b0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic clear_q();
    wr_addr.delete(); wr_data.delete(); rd_addr.delete();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'h5A;
    for (int i = 0; i < 4; i++) begin
      mem[16'h0200 + i] = 8'hA0 + 8'(i);
      mem[16'h0300 + i] = 8'hC0 + 8'(i);
    end
    rst_B = 1'b0; ifc.SELECT_dma = 1'b0; ifc.write_enable_B = 1'b1; ifc.reg_addr = 3'd0;
    cpu_wdata = 8'h00; ifc.in_vblank = 1'b0; ifc.bus_grant = 1'b0;
    #12;
    check("rst_cpu_rdy", 32'(ifc.cpu_rdy), 32'd1);
    check("rst_drive",   32'(ifc.dma_drive), 32'd0);
    check("rst_we_B",    32'(ifc.dma_write_enable_B), 32'd1);
    check("rst_addr",    32'(ifc.dma_address), 32'h0);
    check("rst_dout",    32'(ifc.dma_data_out), 32'h0);
    check("rst_busy",    32'(ifc.busy), 32'd0);
    check("rst_data_out", 32'(ifc.data_out), 32'h0);
`ifdef VRAM_DMA_IRQ_EN
    check("rst_irq", 32'(ifc.dma_irq_B), 32'd1);
`endif
    @(negedge clk); rst_B = 1'b1;

    // 1: basic 4-byte copy, explicit vblank then grant
    clear_q();
    cpu_wr(3'd3, 8'hF0);
    cpu_rd(3'd3, rv); check("t1_dsthi_mask", 32'(rv), 32'h00);
    program_xfer(16'h0200, 12'h010, 8'd4);
    repeat (3) @(negedge clk);
    check("t1_armed_busy", 32'(ifc.busy), 32'd1);
    check("t1_armed_rdy",  32'(ifc.cpu_rdy), 32'd1);
    ifc.in_vblank = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_req_rdy",   32'(ifc.cpu_rdy), 32'd0);
    check("t1_req_drive", 32'(ifc.dma_drive), 32'd0);
    ifc.bus_grant = 1'b1;
    wait_idle(30, "t1_timeout");
    cpu_rd(3'd5, rv); check("t1_status", 32'(rv), 32'h02);
    check("t1_nwr", 32'(wr_addr.size()), 32'd4);
    if (wr_addr.size() == 4 && rd_addr.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check("t1_rd_addr", 32'(rd_addr[i]), 32'h0200 + 32'(i));
        check("t1_wr_addr", 32'(wr_addr[i]), 32'h3010 + 32'(i));
        check("t1_wr_data", 32'(wr_data[i]), 32'hA0 + 32'(i));
      end

    // 2: len=0 -> 256 bytes, src and dst wrap
    @(negedge clk); clear_q();
    program_xfer(16'hFFFF, 12'hFFF, 8'd0);
    wait_idle(1000, "t2_timeout");
    check("t2_nwr", 32'(wr_addr.size()), 32'd256);
    check("t2_nrd", 32'(rd_addr.size()), 32'd256);
    if (wr_addr.size() == 256) begin
      check("t2_rd0",   32'(rd_addr[0]), 32'hFFFF);
      check("t2_rd1",   32'(rd_addr[1]), 32'h0000);
      check("t2_wa0",   32'(wr_addr[0]), 32'h3FFF);
      check("t2_wd0",   32'(wr_data[0]), 32'hA5);
      check("t2_wa1",   32'(wr_addr[1]), 32'h3000);
      check("t2_wd1",   32'(wr_data[1]), 32'h5A);
      check("t2_wa255", 32'(wr_addr[255]), 32'h30FE);
      check("t2_wd255", 32'(wr_data[255]), 32'hA4);
    end

    // 3: suspend after byte 2, resume next vblank
    @(negedge clk); clear_q();
    ifc.in_vblank = 1'b0;
    program_xfer(16'h0300, 12'h020, 8'd4);
    ifc.in_vblank = 1'b1;
    for (int n = 0; n < 50 && wr_addr.size() < 2; n++) begin
      @(negedge clk); #1;
    end
    ifc.in_vblank = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_susp_drive", 32'(ifc.dma_drive), 32'd0);
    check("t3_susp_rdy",   32'(ifc.cpu_rdy), 32'd1);
    check("t3_susp_busy",  32'(ifc.busy), 32'd1);
    check("t3_susp_nwr",   32'(wr_addr.size()), 32'd2);
    ifc.in_vblank = 1'b1;
    wait_idle(30, "t3_timeout");
    check("t3_nwr", 32'(wr_addr.size()), 32'd4);
    if (wr_addr.size() == 4 && rd_addr.size() == 4) begin
      check("t3_rd2", 32'(rd_addr[2]), 32'h0302);
      check("t3_wa2", 32'(wr_addr[2]), 32'h3022);
      check("t3_wd2", 32'(wr_data[2]), 32'hC2);
      check("t3_wa3", 32'(wr_addr[3]), 32'h3023);
    end

    // 4: register write while busy is ignored
    @(negedge clk); clear_q();
    ifc.in_vblank = 1'b0;
    program_xfer(16'h0400, 12'h040, 8'd2);
    cpu_wr(3'd0, 8'h55);
    cpu_rd(3'd0, rv); check("t4_src_lo", 32'(rv), 32'h00);
    ifc.in_vblank = 1'b1;
    wait_idle(30, "t4_timeout");
    check("t4_nwr", 32'(wr_addr.size()), 32'd2);
    if (rd_addr.size() == 2 && wr_addr.size() == 2) begin
      check("t4_rd0", 32'(rd_addr[0]), 32'h0400);
      check("t4_rd1", 32'(rd_addr[1]), 32'h0401);
      check("t4_wa0", 32'(wr_addr[0]), 32'h3040);
    end

`ifdef VRAM_DMA_IRQ_EN
    // 6: completion interrupt and clear-on-status-read
    @(negedge clk); clear_q();
    check("t6_irq_idle", 32'(ifc.dma_irq_B), 32'd1);
    program_xfer(16'h0200, 12'h000, 8'd1);
    wait_idle(30, "t6_timeout");
    check("t6_irq_done", 32'(ifc.dma_irq_B), 32'd0);
    @(negedge clk);
    check("t6_irq_hold", 32'(ifc.dma_irq_B), 32'd0);
    ifc.SELECT_dma = 1'b1; ifc.write_enable_B = 1'b1; ifc.reg_addr = 3'd5;
    @(negedge clk);
    ifc.SELECT_dma = 1'b0;
    #1 check("t6_irq_clr", 32'(ifc.dma_irq_B), 32'd1);
`endif

    // 5: async reset during WRITE releases the bus before any edge
    @(negedge clk); clear_q();
    program_xfer(16'h0500, 12'h050, 8'd4);
    for (int n = 0; n < 50 && ifc.dma_write_enable_B !== 1'b0; n++) begin
      @(negedge clk); #1;
    end
    check("t5_in_write", 32'(ifc.dma_write_enable_B), 32'd0);
    rst_B = 1'b0;
    #1;
    check("t5_drive", 32'(ifc.dma_drive), 32'd0);
    check("t5_rdy",   32'(ifc.cpu_rdy), 32'd1);
    check("t5_we_B",  32'(ifc.dma_write_enable_B), 32'd1);
    cpu_rd(3'd5, rv); check("t5_status", 32'(rv), 32'h00);
    @(negedge clk); rst_B = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
